// File: rtl/aes_pkg.sv
// Shared constants and types for the AES output-side block collector.
// Frames are NBLK cipher blocks packed with the first-received block in the MSBs.
package aes_pkg;

    localparam int BLK_W   = 128;
    localparam int NBLK    = 4;
    localparam int FRAME_W = BLK_W * NBLK;
    localparam int SEQ_W   = 8;
    localparam int IDX_W   = $clog2(NBLK);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/aes_block_collector_if.sv
// Block-in / frame-out bus of the collector, plus per-bank state for observation.
interface aes_block_collector_if;
    import aes_pkg::*;

    // Both channels: a transfer happens on a rising edge where valid && ready.
    // The sender holds data stable while valid is high and ready is low.
    logic               in_valid;
    logic               in_ready;
    logic [BLK_W-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [FRAME_W-1:0] out_data;
    logic [SEQ_W-1:0]   out_seq;
    logic               clr;
    logic [1:0]         dbg_bank0_st;
    logic [1:0]         dbg_bank1_st;

    modport master (
        output clr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_seq, dbg_bank0_st, dbg_bank1_st
    );

    modport slave (
        input  clr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_seq, dbg_bank0_st, dbg_bank1_st
    );

endinterface

// File: rtl/aes_collector_bank.sv
// One frame bank: NBLK slot registers and an EMPTY/FILLING/FULL state machine.
// The owner guarantees wr_en is never raised while the bank is FULL.
module aes_collector_bank
    import aes_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [BLK_W-1:0]   wr_data,
    input  logic               clr_partial,
    input  logic               pop,
    output logic [FRAME_W-1:0] frame,
    output logic               full,
    output logic [1:0]         state
);

    localparam logic [1:0] ST_EMPTY   = BANK_EMPTY;
    localparam logic [1:0] ST_FILLING = BANK_FILLING;
    localparam logic [1:0] ST_FULL    = BANK_FULL;

    logic [1:0]       state_q;
    logic [BLK_W-1:0] slot_q [NBLK];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            for (int k = 0; k < NBLK; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            if (wr_en) begin
                slot_q[wr_idx] <= wr_data;
                state_q        <= (wr_idx == IDX_W'(NBLK - 1)) ? ST_FULL : ST_FILLING;
            end else if (pop && (state_q == ST_FULL)) begin
                state_q <= ST_EMPTY;
            end else if (clr_partial && (state_q == ST_FILLING)) begin
                // Slot contents are left in place; they are overwritten before the bank fills again.
                state_q <= ST_EMPTY;
            end
        end
    end

    always_comb begin
        frame = '0;
        for (int k = 0; k < NBLK; k++) begin
            frame[FRAME_W-1-k*BLK_W -: BLK_W] = slot_q[k];
        end
    end

    assign full  = (state_q == ST_FULL);
    assign state = state_q;

endmodule

// File: rtl/aes_block_collector.sv
// Packs NBLK cipher blocks into one frame using two ping-pong banks, so the core
// can keep filling one bank while the consumer holds the frame in the other.
module aes_block_collector
    import aes_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    aes_block_collector_if.slave bus
);

    logic               wr_bank_q;
    logic               rd_bank_q;
    logic [IDX_W-1:0]   wr_idx_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [FRAME_W-1:0] held_q;
    logic [FRAME_W-1:0] frame [2];
    logic               full [2];
    logic [1:0]         bank_st [2];
    logic               accept;
    logic               pop;

    // in_ready never looks at out_ready: a bank freed by a pop is writable one cycle later.
    assign bus.in_ready  = !RST && !full[wr_bank_q] && !bus.clr;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = full[rd_bank_q];
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_data  = bus.out_valid ? frame[rd_bank_q] : held_q;
    assign bus.out_seq   = seq_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        aes_collector_bank u_bank (
            .CLK         (CLK),
            .RST         (RST),
            .wr_en       (accept && (wr_bank_q == 1'(b))),
            .wr_idx      (wr_idx_q),
            .wr_data     (bus.in_data),
            .clr_partial (bus.clr && (wr_bank_q == 1'(b))),
            .pop         (pop && (rd_bank_q == 1'(b))),
            .frame       (frame[b]),
            .full        (full[b]),
            .state       (bank_st[b])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            seq_q     <= '0;
            held_q    <= '0;
        end else begin
            if (bus.clr) begin
                wr_idx_q <= '0;
            end else if (accept) begin
                if (wr_idx_q == IDX_W'(NBLK - 1)) begin
                    wr_idx_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_idx_q <= wr_idx_q + 1'b1;
                end
            end
            // Keeps the last presented frame on out_data once out_valid drops.
            if (bus.out_valid) begin
                held_q <= frame[rd_bank_q];
            end
            if (pop) begin
                rd_bank_q <= ~rd_bank_q;
                seq_q     <= seq_q + 1'b1;
            end
        end
    end

    assign bus.dbg_bank0_st = bank_st[0];
    assign bus.dbg_bank1_st = bank_st[1];

endmodule

// File: tb/tb_aes_block_collector.sv
// Bench for aes_block_collector: directed scenarios plus a random run, checked
// against a frame-queue model of the collector.
module tb_aes_block_collector;
    import aes_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    aes_block_collector_if bus();

    aes_block_collector dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: completed frames awaiting pop, blocks of the partial frame, popped count.
    logic [FRAME_W-1:0] exp_q[$];
    logic [BLK_W-1:0]   part_q[$];
    logic [FRAME_W-1:0] last_frame = '0;
    int                 pop_cnt = 0;

    function automatic logic m_ready();
        return (exp_q.size() < 2) && !bus.clr;
    endfunction

    function automatic logic m_valid();
        return exp_q.size() > 0;
    endfunction

    function automatic logic [FRAME_W-1:0] m_data();
        return (exp_q.size() > 0) ? exp_q[0] : last_frame;
    endfunction

    function automatic logic [SEQ_W-1:0] m_seq();
        return SEQ_W'(pop_cnt);
    endfunction

    function automatic logic [BLK_W-1:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        part_q.delete();
        last_frame = '0;
        pop_cnt    = 0;
    endtask

    // Advance one clock edge and apply the handshakes of the cycle to the model.
    task automatic tick();
        logic               acc;
        logic               pp;
        logic [FRAME_W-1:0] f;
        acc = bus.in_valid && m_ready();
        pp  = m_valid() && bus.out_ready;
        @(posedge CLK);
        if (pp) begin
            last_frame = exp_q.pop_front();
            pop_cnt++;
        end
        if (bus.clr) begin
            part_q.delete();
        end else if (acc) begin
            part_q.push_back(bus.in_data);
            if (part_q.size() == NBLK) begin
                f = '0;
                for (int k = 0; k < NBLK; k++) f = (f << BLK_W) | FRAME_W'(part_q[k]);
                exp_q.push_back(f);
                part_q.delete();
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        n_cmp++; if (bus.out_seq !== '0) begin n_bad++; $display("FAIL reset_out_seq: got %0d want 0", bus.out_seq); end
        RST = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        tick();
    endtask

    task automatic test_single_frame();
        logic [FRAME_W-1:0] want;
        want = {BLK_W'(1), BLK_W'(2), BLK_W'(3), BLK_W'(4)};
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = BLK_W'(i);
            @(negedge CLK);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid[%0d]: got %b want 0", i, bus.out_valid); end
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge CLK);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== want) begin n_bad++; $display("FAIL single_data: got %h want %h", bus.out_data, want); end
        n_cmp++; if (bus.out_seq !== SEQ_W'(0)) begin n_bad++; $display("FAIL single_seq: got %0d want 0", bus.out_seq); end
        tick();
        @(negedge CLK);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_after_pop_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_seq !== SEQ_W'(1)) begin n_bad++; $display("FAIL single_after_pop_seq: got %0d want 1", bus.out_seq); end
        n_cmp++; if (bus.out_data !== want) begin n_bad++; $display("FAIL single_hold_data: got %h want %h", bus.out_data, want); end
        tick();
    endtask

    task automatic test_backpressure();
        int  sent;
        int  seq0;
        logic acc;
        sent = 0;
        seq0 = pop_cnt;
        bus.out_ready = 1'b0;
        bus.in_data   = rnd_blk();
        for (int c = 0; c < 16; c++) begin
            bus.in_valid = (sent < 12);
            @(negedge CLK);
            n_cmp++; if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want %b", c, bus.in_ready, m_ready()); end
            n_cmp++; if (bus.out_valid !== m_valid()) begin n_bad++; $display("FAIL bp_out_valid[%0d]: got %b want %b", c, bus.out_valid, m_valid()); end
            acc = bus.in_valid && m_ready();
            tick();
            if (acc) begin sent++; bus.in_data = rnd_blk(); end
        end
        @(negedge CLK);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got %b want 0", bus.in_ready); end
        tick();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            bus.in_valid = (sent < 12);
            @(negedge CLK);
            n_cmp++; if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL drain_in_ready[%0d]: got %b want %b", c, bus.in_ready, m_ready()); end
            n_cmp++; if (bus.out_valid !== m_valid()) begin n_bad++; $display("FAIL drain_valid[%0d]: got %b want %b", c, bus.out_valid, m_valid()); end
            n_cmp++; if (bus.out_data !== m_data()) begin n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", c, bus.out_data, m_data()); end
            n_cmp++; if (bus.out_seq !== m_seq()) begin n_bad++; $display("FAIL drain_seq[%0d]: got %0d want %0d", c, bus.out_seq, m_seq()); end
            acc = bus.in_valid && m_ready();
            tick();
            if (acc) begin sent++; bus.in_data = rnd_blk(); end
        end
        bus.in_valid = 1'b0;
        @(negedge CLK);
        n_cmp++; if (bus.out_seq !== SEQ_W'(seq0 + 3)) begin n_bad++; $display("FAIL bp_frames_out: got %0d want %0d", bus.out_seq, SEQ_W'(seq0 + 3)); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", bus.out_valid); end
        tick();
    endtask

    task automatic test_clr();
        logic [BLK_W-1:0]   b [4];
        logic [FRAME_W-1:0] want;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd_blk();
            @(negedge CLK);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_pre_ready[%0d]: got %b want 1", i, bus.in_ready); end
            tick();
        end
        bus.clr     = 1'b1;
        bus.in_data = BLK_W'(8'hAA);
        @(negedge CLK);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL clr_in_ready: got %b want 0", bus.in_ready); end
        tick();
        bus.clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b[i]        = rnd_blk();
            bus.in_data = b[i];
            @(negedge CLK);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_post_ready[%0d]: got %b want 1", i, bus.in_ready); end
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_early_valid[%0d]: got %b want 0", i, bus.out_valid); end
            tick();
        end
        bus.in_valid = 1'b0;
        want = {b[0], b[1], b[2], b[3]};
        @(negedge CLK);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_frame_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== want) begin n_bad++; $display("FAIL clr_frame_data: got %h want %h", bus.out_data, want); end
        tick();
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd_blk();
            @(negedge CLK);
            n_cmp++; if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL hold_fill_ready[%0d]: got %b want %b", i, bus.in_ready, m_ready()); end
            tick();
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b want 1", c, bus.out_valid); end
            n_cmp++; if (bus.out_data !== m_data()) begin n_bad++; $display("FAIL hold_data[%0d]: got %h want %h", c, bus.out_data, m_data()); end
            n_cmp++; if (bus.out_seq !== m_seq()) begin n_bad++; $display("FAIL hold_seq[%0d]: got %0d want %0d", c, bus.out_seq, m_seq()); end
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge CLK);
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_pop_accept();
        logic [SEQ_W-1:0] s0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd_blk();
            @(negedge CLK);
            n_cmp++; if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL pa_fill_ready[%0d]: got %b want %b", i, bus.in_ready, m_ready()); end
            tick();
        end
        bus.in_data   = rnd_blk();
        bus.out_ready = 1'b1;
        @(negedge CLK);
        s0 = m_seq();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL pa_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL pa_out_valid: got %b want 1", bus.out_valid); end
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge CLK);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL pa_next_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_seq !== SEQ_W'(s0 + 1'b1)) begin n_bad++; $display("FAIL pa_next_seq: got %0d want %0d", bus.out_seq, SEQ_W'(s0 + 1'b1)); end
        n_cmp++; if (bus.out_data !== m_data()) begin n_bad++; $display("FAIL pa_next_data: got %h want %h", bus.out_data, m_data()); end
        tick();
        bus.out_ready = 1'b1;
        @(negedge CLK);
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [BLK_W-1:0]   b [4];
        logic [FRAME_W-1:0] want;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd_blk();
            @(negedge CLK);
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge CLK);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_pre_valid: got %b want 1", bus.out_valid); end
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL ar_data: got %h want 0", bus.out_data); end
        n_cmp++; if (bus.out_seq !== '0) begin n_bad++; $display("FAIL ar_seq: got %0d want 0", bus.out_seq); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL ar_in_ready: got %b want 0", bus.in_ready); end
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b[i]         = rnd_blk();
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            @(negedge CLK);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL ar_post_ready[%0d]: got %b want 1", i, bus.in_ready); end
            tick();
        end
        bus.in_valid = 1'b0;
        want = {b[0], b[1], b[2], b[3]};
        @(negedge CLK);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_frame_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_seq !== SEQ_W'(0)) begin n_bad++; $display("FAIL ar_frame_seq: got %0d want 0", bus.out_seq); end
        n_cmp++; if (bus.out_data !== want) begin n_bad++; $display("FAIL ar_frame_data: got %h want %h", bus.out_data, want); end
        tick();
    endtask

    task automatic test_random();
        logic acc;
        bus.in_data = rnd_blk();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) == 0);
            bus.clr       = ($urandom_range(0, 11) == 0);
            @(negedge CLK);
            n_cmp++; if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, bus.in_ready, m_ready()); end
            n_cmp++; if (bus.out_valid !== m_valid()) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus.out_valid, m_valid()); end
            n_cmp++; if (bus.out_data !== m_data()) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", c, bus.out_data, m_data()); end
            n_cmp++; if (bus.out_seq !== m_seq()) begin n_bad++; $display("FAIL rnd_seq[%0d]: got %0d want %0d", c, bus.out_seq, m_seq()); end
            acc = bus.in_valid && m_ready();
            tick();
            if (acc) bus.in_data = rnd_blk();
        end
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_clr();
        test_hold();
        test_pop_accept();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_block_collector.md
Name: aes_block_collector

Overview:
Output-side stage placed directly downstream of the pipelined AES round datapath. It accepts 128-bit ciphertext blocks one at a time over a valid/ready handshake and packs NBLK consecutive blocks into one 512-bit frame. Frames are presented to the system side over a second valid/ready handshake. Two ping-pong frame banks let the core keep emitting blocks while the consumer holds the previous frame.

Parameters:
BLK_W, 128, width of one cipher block
NBLK, 4, blocks per frame (power of two, >=2)
SEQ_W, 8, width of frame sequence counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset; asynchronous, active-high
clr  in  1  synchronous abort of the partially filled frame
in_valid  in  1  cipher block available from core
in_ready  out  1  collector can accept a block this cycle
in_data  in  BLK_W  cipher block
out_valid  out  1  complete frame available
out_ready  in  1  consumer takes frame this cycle
out_data  out  BLK_W*NBLK  packed frame, first-received block in MSBs
out_seq  out  SEQ_W  sequence number of the presented frame

Behaviour:
- Reset, asynchronous, active-high. Clears both banks to EMPTY and all slot registers to 0. Sets wr_bank=0, rd_bank=0, wr_idx=0, out_valid=0, out_data=0, out_seq=0. in_ready=0 while RST is high and 1 in the first cycle after release.
- Bank state: each bank is EMPTY, FILLING or FULL. wr_bank/wr_idx mark the write target; rd_bank marks the bank under presentation.
- in_ready = !FULL(wr_bank) && !clr. It is combinational from registered state only; there is no path from out_ready.
- Accept (in_valid && in_ready):
  - Block k of a frame is written to bits [BLK_W*NBLK-1-k*BLK_W -: BLK_W] of the bank. Block 0 lands in [511:384].
  - wr_idx is incremented.
  - At wr_idx==NBLK-1 the bank becomes FULL, wr_bank toggles and wr_idx wraps to 0.
- out_valid = FULL(rd_bank), registered. The last block accepted at edge N gives out_valid=1 after edge N, visible in cycle N+1. Minimum latency is 1 cycle from the final accept.
- out_data is a mux of bank rd_bank. It is stable while out_valid && !out_ready. When out_valid=0, out_data holds its last value.
- Pop (out_valid && out_ready):
  - Bank rd_bank becomes EMPTY and rd_bank toggles.
  - out_seq increments modulo 2^SEQ_W. out_seq counts presented frames from 0.
- Simultaneous pop and accept:
  - Both take effect in the same cycle.
  - A bank freed by the pop is writable the following cycle, not the same cycle.
- Both banks FULL: in_ready=0. The core must hold in_data/in_valid. No block is ever dropped or overwritten.
- clr=1:
  - Discards the FILLING bank: it becomes EMPTY and wr_idx=0.
  - in_ready is forced to 0, so a block presented that cycle is not accepted.
  - FULL banks, out_valid, out_data and out_seq are unaffected.
  - clr together with pop: both take effect.
- in_valid while in_ready=0: no state change.
- Reset asserted mid-frame or mid-presentation: all partial and full frames are lost; outputs return to reset values immediately.

Decomposition:
- Package aes_pkg:
  - BLK_W, NBLK, FRAME_W = BLK_W*NBLK, SEQ_W
  - bank state enum {BANK_EMPTY, BANK_FILLING, BANK_FULL}
- One sub-module, aes_collector_bank:
  - holds NBLK slot registers plus its state
  - inputs: wr_en, wr_idx, wr_data, clr_partial, pop
  - outputs: frame, full
  - instantiated twice
- The top level holds wr_bank/rd_bank/wr_idx/out_seq and the handshake logic.

Test Plan:
- Reset then stream 4 blocks 0x..01, 0x..02, 0x..03, 0x..04 back-to-back, out_ready=1 -> out_valid rises 1 cycle after the 4th accept; out_data = {01,02,03,04} with 01 in [511:384]; out_seq=0, and 1 after the pop.
- out_ready=0, stream 12 blocks continuously -> in_ready drops after block 8. Then raise out_ready -> frames 0,1,2 emerge in order with seq 0,1,2 and no lost or duplicated block.
- Send 2 blocks, pulse clr with in_valid=1 and data 0xAA, then send 4 blocks B0..B3 -> 0xAA not accepted; the frame is {B0,B1,B2,B3}; the earlier 2 blocks are absent.
- Frame pending with out_ready=0 for 20 cycles -> out_data and out_seq stable throughout; out_valid stays 1.
- Assert RST asynchronously mid-frame (wr_idx=2) and while a frame is presented -> out_valid=0, out_data=0, out_seq=0 immediately; the next 4 blocks form frame seq 0.
- Pop and accept in the same cycle with one bank FULL and the other FILLING at wr_idx=3 -> both succeed; the next frame is presented with seq+1 in the following cycle.
